// File: rtl/snake_pkg.sv
// Headings, sequencer state codes and default playfield size shared by the
// snake sequencer, renderer and turn logic.
package snake_pkg;

  localparam int GRID_W_DEFAULT = 80;
  localparam int GRID_H_DEFAULT = 60;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_UP    = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_WAIT_TIK = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_HEAD     = 3'd4,
    ST_OVER     = 3'd5
  } state_t;

  // SHIFT starts with one setup cycle, then alternates read / write per segment.
  typedef enum logic [1:0] {
    PH_SETUP = 2'd0,
    PH_READ  = 2'd1,
    PH_WRITE = 2'd2
  } shift_phase_t;

  // Opposite headings differ only in the axis-sign bit (right<->left, up<->down).
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return (a ^ b) == 2'b10;
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head cell and wall check; up decrements y, down increments y.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEFAULT,
  parameter int GRID_H = GRID_H_DEFAULT
) (
  input  logic [6:0] head_x,
  input  logic [6:0] head_y,
  input  dir_t       dir,
  output logic [6:0] next_x,
  output logic [6:0] next_y,
  output logic       wall
);

  logic [7:0] sum_x;
  logic [7:0] sum_y;

  // 8-bit arithmetic so 0-1 shows up as bit 7 set instead of wrapping to a legal cell.
  always_comb begin
    sum_x = {1'b0, head_x};
    sum_y = {1'b0, head_y};
    case (dir)
      DIR_RIGHT: sum_x = {1'b0, head_x} + 8'd1;
      DIR_LEFT:  sum_x = {1'b0, head_x} - 8'd1;
      DIR_UP:    sum_y = {1'b0, head_y} - 8'd1;
      DIR_DOWN:  sum_y = {1'b0, head_y} + 8'd1;
    endcase
    wall   = sum_x[7] | sum_y[7] | (sum_x >= 8'(GRID_W)) | (sum_y >= 8'(GRID_H));
    next_x = sum_x[6:0];
    next_y = sum_y[6:0];
  end

endmodule

// File: rtl/snake_move_sequencer.sv
// Snake move sequencer: builds the initial body, then on each game tick shifts the
// body RAM one slot toward the tail, checks walls/self-collision and writes the new head.
module snake_move_sequencer
  import snake_pkg::*;
#(
  parameter int SNAKE_LENGTH_BIT = 6,
  parameter int GRID_W           = GRID_W_DEFAULT,
  parameter int GRID_H           = GRID_H_DEFAULT,
  parameter int INIT_LENGTH      = 3
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        game_tik,
  input  logic [1:0]                  direction,
  input  logic [6:0]                  fruit_x,
  input  logic [6:0]                  fruit_y,
  input  logic [6:0]                  body_rd_x,
  input  logic [6:0]                  body_rd_y,
  output logic [SNAKE_LENGTH_BIT-1:0] body_addr,
  output logic                        body_we,
  output logic [6:0]                  body_wr_x,
  output logic [6:0]                  body_wr_y,
  output logic [6:0]                  snake_head_x,
  output logic [6:0]                  snake_head_y,
  output logic [SNAKE_LENGTH_BIT-1:0] snake_length,
  output logic                        fruit_eaten,
  output logic                        game_over,
  output logic                        busy,
  output logic [2:0]                  current_state
);

  localparam logic [SNAKE_LENGTH_BIT-1:0] SEG_ONE  = SNAKE_LENGTH_BIT'(1);
  localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_MAX  = '1;
  localparam logic [SNAKE_LENGTH_BIT-1:0] INIT_LEN = SNAKE_LENGTH_BIT'(INIT_LENGTH);
  localparam logic [6:0]                  CENTER_X = 7'(GRID_W / 2);
  localparam logic [6:0]                  CENTER_Y = 7'(GRID_H / 2);

  state_t                      state;
  state_t                      state_nxt;
  shift_phase_t                phase;
  dir_t                        heading;
  dir_t                        eff_dir;
  logic [SNAKE_LENGTH_BIT-1:0] idx;
  logic [SNAKE_LENGTH_BIT-1:0] top;
  logic [6:0]                  next_head_x;
  logic [6:0]                  next_head_y;
  logic [6:0]                  calc_x;
  logic [6:0]                  calc_y;
  logic                        wall;
  logic                        grow;
  logic                        collide;
  logic                        len_grows;

  assign eff_dir   = is_opposite(dir_t'(direction), heading) ? heading : dir_t'(direction);
  assign len_grows = grow && (snake_length != LEN_MAX);
  assign top       = len_grows ? snake_length : snake_length - SEG_ONE;

  snake_next_head #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H)
  ) u_next_head (
    .head_x(snake_head_x),
    .head_y(snake_head_y),
    .dir   (eff_dir),
    .next_x(calc_x),
    .next_y(calc_y),
    .wall  (wall)
  );

  always_ff @(posedge clock_25) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (start) state_nxt = ST_INIT;
      ST_INIT:     if (idx == INIT_LEN - SEG_ONE) state_nxt = ST_WAIT_TIK;
      ST_WAIT_TIK: if (game_tik) state_nxt = wall ? ST_OVER : ST_SHIFT;
      ST_SHIFT: begin
        if ((phase == PH_SETUP && top == '0) || (phase == PH_WRITE && idx == SEG_ONE))
          state_nxt = ST_HEAD;
      end
      ST_HEAD:     state_nxt = collide ? ST_OVER : ST_WAIT_TIK;
      ST_OVER:     if (start) state_nxt = ST_INIT;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      idx          <= '0;
      phase        <= PH_SETUP;
      heading      <= DIR_RIGHT;
      next_head_x  <= '0;
      next_head_y  <= '0;
      grow         <= 1'b0;
      collide      <= 1'b0;
      snake_head_x <= '0;
      snake_head_y <= '0;
      snake_length <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_OVER: idx <= '0;
        ST_INIT: begin
          idx <= idx + SEG_ONE;
          if (idx == INIT_LEN - SEG_ONE) begin
            heading      <= DIR_RIGHT;
            snake_length <= INIT_LEN;
            snake_head_x <= CENTER_X;
            snake_head_y <= CENTER_Y;
          end
        end
        ST_WAIT_TIK: begin
          if (game_tik) begin
            heading     <= eff_dir;
            next_head_x <= calc_x;
            next_head_y <= calc_y;
            grow        <= (calc_x == fruit_x) && (calc_y == fruit_y);
            collide     <= 1'b0;
            phase       <= PH_SETUP;
          end
        end
        ST_SHIFT: begin
          case (phase)
            PH_SETUP: begin
              idx   <= top;
              phase <= PH_READ;
            end
            PH_READ: phase <= PH_WRITE;
            default: begin
              // The tail slot (index length-1) is vacated this step, so it cannot be hit.
              if (idx < snake_length && body_rd_x == next_head_x && body_rd_y == next_head_y)
                collide <= 1'b1;
              idx   <= idx - SEG_ONE;
              phase <= PH_READ;
            end
          endcase
        end
        ST_HEAD: begin
          if (!collide) begin
            snake_head_x <= next_head_x;
            snake_head_y <= next_head_y;
            if (len_grows) snake_length <= snake_length + SEG_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    body_addr     = '0;
    body_we       = 1'b0;
    body_wr_x     = '0;
    body_wr_y     = '0;
    busy          = 1'b0;
    fruit_eaten   = 1'b0;
    game_over     = 1'b0;
    current_state = state;
    case (state)
      ST_INIT: begin
        busy      = 1'b1;
        body_we   = 1'b1;
        body_addr = idx;
        body_wr_x = CENTER_X - 7'(idx);
        body_wr_y = CENTER_Y;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (phase == PH_READ) begin
          body_addr = idx - SEG_ONE;
        end else if (phase == PH_WRITE) begin
          body_addr = idx;
          body_we   = 1'b1;
          body_wr_x = body_rd_x;
          body_wr_y = body_rd_y;
        end
      end
      ST_HEAD: begin
        busy        = 1'b1;
        fruit_eaten = grow;
        if (!collide) begin
          body_we   = 1'b1;
          body_wr_x = next_head_x;
          body_wr_y = next_head_y;
        end
      end
      ST_OVER: game_over = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_snake_move_sequencer.sv
// Bench for snake_move_sequencer: a behavioural RAM plus a queue-based snake model.
module tb_snake_move_sequencer;
  import snake_pkg::*;

  localparam int LB      = 6;
  localparam int MAX_LEN = (1 << LB) - 1;

  logic          clock_25 = 1'b0;
  logic          reset, start, game_tik;
  logic [1:0]    direction;
  logic [6:0]    fruit_x, fruit_y, body_rd_x, body_rd_y;
  logic [LB-1:0] body_addr;
  logic          body_we;
  logic [6:0]    body_wr_x, body_wr_y, snake_head_x, snake_head_y;
  logic [LB-1:0] snake_length;
  logic          fruit_eaten, game_over, busy;
  logic [2:0]    current_state;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_we, cnt_busy, cnt_fruit;
  int wr_addr_log[$];
  logic [6:0] ram_x [64];
  logic [6:0] ram_y [64];

  // Snake model: index 0 is the head.
  int mq_x[$];
  int mq_y[$];
  int m_heading;

  always #20 clock_25 = ~clock_25;

  snake_move_sequencer #(
    .SNAKE_LENGTH_BIT(LB), .GRID_W(80), .GRID_H(60), .INIT_LENGTH(3)
  ) dut (
    .clock_25(clock_25), .reset(reset), .start(start), .game_tik(game_tik),
    .direction(direction), .fruit_x(fruit_x), .fruit_y(fruit_y),
    .body_rd_x(body_rd_x), .body_rd_y(body_rd_y), .body_addr(body_addr),
    .body_we(body_we), .body_wr_x(body_wr_x), .body_wr_y(body_wr_y),
    .snake_head_x(snake_head_x), .snake_head_y(snake_head_y),
    .snake_length(snake_length), .fruit_eaten(fruit_eaten), .game_over(game_over),
    .busy(busy), .current_state(current_state)
  );

  always @(posedge clock_25) begin
    if (body_we) begin
      ram_x[body_addr] <= body_wr_x;
      ram_y[body_addr] <= body_wr_y;
      cnt_we++;
      wr_addr_log.push_back(int'(body_addr));
    end
    if (busy) cnt_busy++;
    if (fruit_eaten) cnt_fruit++;
    body_rd_x <= ram_x[body_addr];
    body_rd_y <= ram_y[body_addr];
  end

  function automatic void model_init();
    mq_x.delete();
    mq_y.delete();
    for (int i = 0; i < 3; i++) begin
      mq_x.push_back(40 - i);
      mq_y.push_back(30);
    end
    m_heading = 0;
  endfunction

  function automatic void next_cell(input int dir, output int eff, output int nx, output int ny);
    eff = ((dir ^ m_heading) == 2) ? m_heading : dir;
    nx  = mq_x[0];
    ny  = mq_y[0];
    case (eff)
      0:       nx = nx + 1;
      1:       ny = ny - 1;
      2:       nx = nx - 1;
      default: ny = ny + 1;
    endcase
  endfunction

  // outcome: 0 moved, 1 wall, 2 self collision
  function automatic void model_step(input int dir, input int fx, input int fy,
                                     output int outcome, output bit grow,
                                     output int cycles, output int writes);
    int eff, nx, ny, len, top;
    bit lengthen;
    next_cell(dir, eff, nx, ny);
    m_heading = eff;
    grow = 0; cycles = 0; writes = 0;
    if (nx < 0 || nx >= 80 || ny < 0 || ny >= 60) begin
      outcome = 1;
      return;
    end
    grow     = (nx == fx) && (ny == fy);
    len      = mq_x.size();
    lengthen = grow && (len < MAX_LEN);
    top      = lengthen ? len : len - 1;
    cycles   = 2 * top + 2;
    outcome  = 0;
    for (int i = 0; i <= len - 2; i++)
      if (mq_x[i] == nx && mq_y[i] == ny) outcome = 2;
    if (outcome == 2) begin
      writes = top;
      return;
    end
    writes = top + 1;
    mq_x.push_front(nx);
    mq_y.push_front(ny);
    if (!lengthen) begin
      void'(mq_x.pop_back());
      void'(mq_y.pop_back());
    end
  endfunction

  task automatic apply_reset();
    reset = 1'b1; start = 1'b0; game_tik = 1'b0;
    repeat (2) @(negedge clock_25);
    reset = 1'b0;
  endtask

  task automatic start_game();
    int guard = 0;
    cnt_we = 0; cnt_busy = 0; cnt_fruit = 0;
    wr_addr_log.delete();
    start = 1'b1;
    @(negedge clock_25);
    start = 1'b0;
    while (current_state !== ST_WAIT_TIK && guard < 50) begin
      @(negedge clock_25);
      guard++;
    end
    if (guard >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL start_timeout state=%0d want %0d", current_state, ST_WAIT_TIK);
    end
    model_init();
  endtask

  task automatic do_tik(input logic [1:0] d, input logic [6:0] fx, input logic [6:0] fy);
    int guard = 0;
    direction = d; fruit_x = fx; fruit_y = fy;
    cnt_we = 0; cnt_busy = 0; cnt_fruit = 0;
    wr_addr_log.delete();
    game_tik = 1'b1;
    @(negedge clock_25);
    game_tik = 1'b0;
    while ((current_state === ST_SHIFT || current_state === ST_HEAD) && guard < 300) begin
      @(negedge clock_25);
      guard++;
    end
    if (guard >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL step_timeout state=%0d still busy", current_state);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({current_state, snake_length, snake_head_x, snake_head_y} !== '0) begin
      n_err++;
      $display("FAIL reset_regs got state=%0d len=%0d head=(%0d,%0d) want all 0",
               current_state, snake_length, snake_head_x, snake_head_y);
    end
    n_cmp++;
    if ({body_we, busy, game_over, fruit_eaten, body_addr, body_wr_x, body_wr_y} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got we=%0b busy=%0b over=%0b fe=%0b addr=%0d want 0",
               body_we, busy, game_over, fruit_eaten, body_addr);
    end
    direction = 2'b11;
    game_tik  = 1'b1;
    @(negedge clock_25);
    game_tik = 1'b0;
    @(negedge clock_25);
    n_cmp++;
    if (current_state !== ST_IDLE || cnt_we != 0) begin
      n_err++;
      $display("FAIL idle_ignores_tik got state=%0d writes=%0d want %0d/0", current_state, cnt_we, ST_IDLE);
    end
  endtask

  task automatic test_init();
    bit ok;
    apply_reset();
    start_game();
    n_cmp++;
    ok = (wr_addr_log.size() == 3);
    if (ok) for (int i = 0; i < 3; i++) if (wr_addr_log[i] != i) ok = 0;
    if (!ok) begin
      n_err++;
      $display("FAIL init_addr_order got %0d writes want addr 0,1,2", wr_addr_log.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({ram_x[i], ram_y[i]} !== {7'(40 - i), 7'd30}) begin
        n_err++;
        $display("FAIL init_body%0d got (%0d,%0d) want (%0d,30)", i, ram_x[i], ram_y[i], 40 - i);
      end
    end
    n_cmp++;
    if (snake_length !== 6'd3 || current_state !== ST_WAIT_TIK || cnt_busy != 3) begin
      n_err++;
      $display("FAIL init_done got len=%0d state=%0d busy=%0d want 3/%0d/3",
               snake_length, current_state, cnt_busy, ST_WAIT_TIK);
    end
  endtask

  task automatic test_step_right();
    int outcome, cycles, writes;
    bit grow;
    apply_reset();
    start_game();
    model_step(0, 5, 5, outcome, grow, cycles, writes);
    do_tik(2'b00, 7'd5, 7'd5);
    n_cmp++;
    if ({snake_head_x, snake_head_y} !== {7'd41, 7'd30}) begin
      n_err++;
      $display("FAIL step_head got (%0d,%0d) want (41,30)", snake_head_x, snake_head_y);
    end
    n_cmp++;
    if ({ram_x[0], ram_y[0], ram_x[1], ram_y[1], ram_x[2], ram_y[2]} !==
        {7'(mq_x[0]), 7'(mq_y[0]), 7'(mq_x[1]), 7'(mq_y[1]), 7'(mq_x[2]), 7'(mq_y[2])}) begin
      n_err++;
      $display("FAIL step_body got (%0d,%0d)(%0d,%0d) want (%0d,%0d)(%0d,%0d)",
               ram_x[1], ram_y[1], ram_x[2], ram_y[2], mq_x[1], mq_y[1], mq_x[2], mq_y[2]);
    end
    n_cmp++;
    if (cnt_busy != cycles || cnt_fruit != 0 || snake_length !== 6'd3) begin
      n_err++;
      $display("FAIL step_timing got busy=%0d fruit=%0d len=%0d want %0d/0/3",
               cnt_busy, cnt_fruit, snake_length, cycles);
    end
  endtask

  task automatic test_grow();
    int outcome, cycles, writes;
    bit grow;
    apply_reset();
    start_game();
    model_step(0, 41, 30, outcome, grow, cycles, writes);
    do_tik(2'b00, 7'd41, 7'd30);
    n_cmp++;
    if (cnt_fruit != 1 || snake_length !== 6'd4 || cnt_busy != cycles) begin
      n_err++;
      $display("FAIL grow_len got fruit=%0d len=%0d busy=%0d want 1/4/%0d",
               cnt_fruit, snake_length, cnt_busy, cycles);
    end
    n_cmp++;
    if ({ram_x[3], ram_y[3]} !== {7'd38, 7'd30}) begin
      n_err++;
      $display("FAIL grow_tail got (%0d,%0d) want (38,30)", ram_x[3], ram_y[3]);
    end
  endtask

  task automatic test_reverse_and_wall();
    int outcome, cycles, writes;
    bit grow;
    apply_reset();
    start_game();
    model_step(2, 0, 0, outcome, grow, cycles, writes);
    do_tik(2'b10, 7'd0, 7'd0);
    n_cmp++;
    if ({snake_head_x, snake_head_y} !== {7'd41, 7'd30}) begin
      n_err++;
      $display("FAIL reverse_ignored got head (%0d,%0d) want (41,30)", snake_head_x, snake_head_y);
    end
    while (mq_x[0] < 79) begin
      model_step(0, 0, 0, outcome, grow, cycles, writes);
      do_tik(2'b00, 7'd0, 7'd0);
    end
    n_cmp++;
    if ({snake_head_x, snake_head_y} !== {7'd79, 7'd30}) begin
      n_err++;
      $display("FAIL wall_approach got head (%0d,%0d) want (79,30)", snake_head_x, snake_head_y);
    end
    do_tik(2'b00, 7'd0, 7'd0);
    n_cmp++;
    if (current_state !== ST_OVER || game_over !== 1'b1 || cnt_we != 0 || cnt_busy != 0) begin
      n_err++;
      $display("FAIL wall_over got state=%0d over=%0b writes=%0d busy=%0d want %0d/1/0/0",
               current_state, game_over, cnt_we, cnt_busy, ST_OVER);
    end
  endtask

  task automatic test_self_collision();
    int outcome, cycles, writes;
    bit grow;
    apply_reset();
    start_game();
    model_step(0, 41, 30, outcome, grow, cycles, writes);
    do_tik(2'b00, 7'd41, 7'd30);
    model_step(0, 42, 30, outcome, grow, cycles, writes);
    do_tik(2'b00, 7'd42, 7'd30);
    n_cmp++;
    if (snake_length !== 6'd5) begin
      n_err++;
      $display("FAIL collide_setup got len=%0d want 5", snake_length);
    end
    model_step(3, 0, 0, outcome, grow, cycles, writes);
    do_tik(2'b11, 7'd0, 7'd0);
    model_step(2, 0, 0, outcome, grow, cycles, writes);
    do_tik(2'b10, 7'd0, 7'd0);
    model_step(1, 0, 0, outcome, grow, cycles, writes);
    do_tik(2'b01, 7'd0, 7'd0);
    n_cmp++;
    if (game_over !== 1'b1 || current_state !== ST_OVER || cnt_busy != cycles) begin
      n_err++;
      $display("FAIL collide_over got over=%0b state=%0d busy=%0d want 1/%0d/%0d",
               game_over, current_state, cnt_busy, ST_OVER, cycles);
    end
    n_cmp++;
    if ({snake_head_x, snake_head_y, snake_length} !== {7'(mq_x[0]), 7'(mq_y[0]), 6'd5}) begin
      n_err++;
      $display("FAIL collide_head got (%0d,%0d) len=%0d want (%0d,%0d) 5",
               snake_head_x, snake_head_y, snake_length, mq_x[0], mq_y[0]);
    end
    start = 1'b1;
    @(negedge clock_25);
    start = 1'b0;
    n_cmp++;
    if (current_state !== ST_INIT || game_over !== 1'b0) begin
      n_err++;
      $display("FAIL restart got state=%0d over=%0b want %0d/0", current_state, game_over, ST_INIT);
    end
    repeat (5) @(negedge clock_25);
  endtask

  task automatic test_drop_tik();
    int outcome, cycles, writes;
    bit grow;
    apply_reset();
    start_game();
    model_step(0, 5, 5, outcome, grow, cycles, writes);
    direction = 2'b00; fruit_x = 7'd5; fruit_y = 7'd5;
    cnt_busy = 0;
    game_tik = 1'b1;
    @(negedge clock_25);
    game_tik = 1'b0;
    @(negedge clock_25);
    direction = 2'b11;
    game_tik  = 1'b1;
    @(negedge clock_25);
    game_tik = 1'b0;
    repeat (15) @(negedge clock_25);
    n_cmp++;
    if ({snake_head_x, snake_head_y} !== {7'(mq_x[0]), 7'(mq_y[0])} ||
        current_state !== ST_WAIT_TIK || cnt_busy != cycles) begin
      n_err++;
      $display("FAIL drop_tik got head (%0d,%0d) state=%0d busy=%0d want (%0d,%0d)/%0d/%0d",
               snake_head_x, snake_head_y, current_state, cnt_busy, mq_x[0], mq_y[0],
               ST_WAIT_TIK, cycles);
    end
  endtask

  task automatic test_reset_mid_shift();
    int guard = 0;
    apply_reset();
    start_game();
    direction = 2'b00; fruit_x = 7'd5; fruit_y = 7'd5;
    game_tik = 1'b1;
    @(negedge clock_25);
    game_tik = 1'b0;
    while (!(current_state === ST_SHIFT && body_we === 1'b1) && guard < 20) begin
      @(negedge clock_25);
      guard++;
    end
    n_cmp++;
    if (guard >= 20) begin
      n_err++;
      $display("FAIL mid_shift_reach got state=%0d we=%0b want shift write", current_state, body_we);
    end
    reset = 1'b1;
    @(negedge clock_25);
    n_cmp++;
    if (current_state !== ST_IDLE || body_we !== 1'b0 || busy !== 1'b0 ||
        snake_length !== '0 || {snake_head_x, snake_head_y} !== '0) begin
      n_err++;
      $display("FAIL mid_shift_reset got state=%0d we=%0b busy=%0b len=%0d want idle/0/0/0",
               current_state, body_we, busy, snake_length);
    end
    reset = 1'b0;
    @(negedge clock_25);
  endtask

  task automatic test_random();
    int eff, nx, ny, outcome, cycles, writes, fx, fy, d;
    bit grow, ram_ok;
    for (int g = 0; g < 4; g++) begin
      apply_reset();
      start_game();
      for (int s = 0; s < 60; s++) begin
        d = int'($urandom_range(0, 3));
        next_cell(d, eff, nx, ny);
        if ($urandom_range(0, 2) == 0) begin
          fx = nx; fy = ny;
        end else begin
          fx = int'($urandom_range(0, 79)); fy = int'($urandom_range(0, 59));
        end
        model_step(d, fx, fy, outcome, grow, cycles, writes);
        do_tik(2'(d), 7'(fx), 7'(fy));
        n_cmp++;
        if (current_state !== ((outcome == 0) ? ST_WAIT_TIK : ST_OVER) ||
            game_over !== (outcome != 0)) begin
          n_err++;
          $display("FAIL rnd_state g=%0d s=%0d got state=%0d over=%0b want outcome %0d",
                   g, s, current_state, game_over, outcome);
        end
        n_cmp++;
        if ({snake_head_x, snake_head_y, snake_length} !==
            {7'(mq_x[0]), 7'(mq_y[0]), 6'(mq_x.size())}) begin
          n_err++;
          $display("FAIL rnd_head g=%0d s=%0d got (%0d,%0d) len=%0d want (%0d,%0d) len=%0d",
                   g, s, snake_head_x, snake_head_y, snake_length, mq_x[0], mq_y[0], mq_x.size());
        end
        n_cmp++;
        if (cnt_busy != cycles || cnt_we != writes || cnt_fruit != int'(grow)) begin
          n_err++;
          $display("FAIL rnd_counts g=%0d s=%0d got busy=%0d we=%0d fruit=%0d want %0d/%0d/%0d",
                   g, s, cnt_busy, cnt_we, cnt_fruit, cycles, writes, grow);
        end
        if (outcome == 0) begin
          ram_ok = 1;
          for (int i = 0; i < mq_x.size(); i++)
            if ({ram_x[i], ram_y[i]} !== {7'(mq_x[i]), 7'(mq_y[i])}) ram_ok = 0;
          n_cmp++;
          if (!ram_ok) begin
            n_err++;
            $display("FAIL rnd_body g=%0d s=%0d body RAM differs from model, len=%0d",
                     g, s, mq_x.size());
          end
        end
        if (outcome != 0) break;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; game_tik = 1'b0;
    direction = 2'b00; fruit_x = '0; fruit_y = '0;
    cnt_we = 0; cnt_busy = 0; cnt_fruit = 0;
    test_reset();
    test_init();
    test_step_right();
    test_grow();
    test_reverse_and_wall();
    test_self_collision();
    test_drop_tik();
    test_reset_mid_shift();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000000;
    $display("FAIL watchdog simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/snake_move_sequencer.md
SNAKE_MOVE_SEQUENCER -- requirements
Module: snake_move_sequencer

Interface
REQ-001 SHALL have parameter SNAKE_LENGTH_BIT, default 6, width of segment index and length.
REQ-002 SHALL have parameter GRID_W, default 80, and GRID_H, default 60, the playfield size in cells.
REQ-003 SHALL have parameter INIT_LENGTH, default 3, the snake length after INIT.
REQ-004 SHALL have port clock_25 input 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset input 1: synchronous, active-high reset.
REQ-006 SHALL have start input 1: one-cycle pulse that begins a game.
REQ-007 SHALL have game_tik input 1: one-cycle pulse that requests one move step.
REQ-008 SHALL have direction input 2: requested heading; 00 right, 01 up, 10 left, 11 down.
REQ-009 SHALL have fruit_x and fruit_y inputs, 7 bits each: fruit cell.
REQ-010 SHALL have body_rd_x and body_rd_y inputs, 7 bits each: body RAM read data, valid one cycle after body_addr.
REQ-011 SHALL have body_addr output SNAKE_LENGTH_BIT, body_we output 1, and body_wr_x, body_wr_y outputs 7 bits each: body RAM port; index 0 is the head.
REQ-012 SHALL have snake_head_x and snake_head_y outputs, 7 bits each, and snake_length output SNAKE_LENGTH_BIT.
REQ-013 SHALL have fruit_eaten output 1 (pulse), game_over output 1 (level), busy output 1, and current_state output 3.

Function
REQ-014 SHALL implement the states IDLE, INIT, WAIT_TIK, SHIFT, HEAD and OVER; current_state exposes the encoding.
REQ-015 IDLE: start → INIT; all other inputs are ignored.
REQ-016 INIT: SHALL write body[i] = (GRID_W/2 - i, GRID_H/2) for i = 0..INIT_LENGTH-1, one write per cycle.
REQ-017 INIT: SHALL set the heading to right and snake_length = INIT_LENGTH, then go to WAIT_TIK.
REQ-018 WAIT_TIK: on game_tik, SHALL latch direction into the heading.
REQ-019 The latched direction SHALL be ignored when it is the exact opposite of the current heading; the heading is then unchanged.
REQ-020 On the same game_tik, SHALL compute next_head = head ± 1 on one axis using 8-bit arithmetic.
REQ-021 If next_head x ≥ GRID_W, y ≥ GRID_H, or the subtraction underflows, SHALL go to OVER without any RAM write.
REQ-022 Otherwise SHALL set grow = (next_head == fruit) and go to SHIFT.
REQ-023 SHIFT: SHALL set top = snake_length if grow and snake_length < 2^SNAKE_LENGTH_BIT - 1, else top = snake_length - 1.
REQ-024 SHIFT: for i = top down to 1, SHALL read addr i-1, then write the returned data to addr i on the next cycle (2 cycles per segment).
REQ-025 SHIFT: each returned body[i-1] with i-1 ≤ snake_length-2 SHALL be compared with next_head; any match sets a self-collision flag.
REQ-026 HEAD: if the self-collision flag is set, SHALL go to OVER; otherwise it writes next_head to addr 0.
REQ-027 HEAD (no collision): SHALL update snake_head_x/y, increment snake_length if it grew, and return to WAIT_TIK.
REQ-028 fruit_eaten SHALL pulse for exactly one cycle in HEAD when grow = 1, including when length is saturated.
REQ-029 game_tik arriving outside WAIT_TIK SHALL be dropped, not queued.
REQ-030 busy SHALL be 1 in INIT, SHIFT and HEAD; body_we SHALL be 0 in every other state.
REQ-031 OVER: game_over = 1; start → INIT (game_over clears on entry to INIT).
REQ-032 A step SHALL complete in 2·top + 2 cycles after game_tik.

Reset
REQ-033 reset SHALL, at any cycle including mid-SHIFT, force state IDLE and set all outputs to 0 (snake_length = 0, heading right) on the next edge.
REQ-034 RAM contents after reset SHALL be undefined; INIT rewrites them.

Structure
REQ-035 snake_pkg SHALL hold the direction codes, state encodings, and GRID_W/GRID_H defaults shared with the renderer and turn logic.
REQ-036 The next-head and wall check SHALL be a combinational sub-module, snake_next_head.

Verification
REQ-037 Verification SHALL cover: reset, start → writes (40,30),(39,30),(38,30) to addr 0..2, snake_length=3, then WAIT_TIK.
REQ-038 Verification SHALL cover: game_tik, direction=00, no fruit → head (41,30), body (40,30),(39,30), busy for 6 cycles, no fruit_eaten.
REQ-039 Verification SHALL cover: fruit at (41,30), game_tik → fruit_eaten 1 cycle, snake_length=4, tail (38,30) retained at addr 3.
REQ-040 Verification SHALL cover: direction=10 while heading right → heading stays right; drive head to x=79 and tik → OVER, no RAM write.
REQ-041 Verification SHALL cover: a length-5 snake turning down, left, up into itself → game_over=1 in OVER; start → INIT.
REQ-042 Verification SHALL cover: reset asserted mid-SHIFT → IDLE next cycle, body_we=0; game_tik during SHIFT is dropped.
